read_burst_arbiter: RTL and testbench
=====================================

Name: read_burst_arbiter

Overview:
- Round-robin arbiter for the single core read channel (request + data beats), shared between N burst masters (DMA controller, accelerator, ...).
- Once granted, a master owns the channel until its whole burst is delivered. Interleaving of beats between masters is impossible.
- Replaces the static busy-flag mux in front of the core read port, so the DMA and the accelerator can share the channel concurrently.

Parameters:
- AXI_AWIDTH, 32, address width
- AXI_DWIDTH, 32, data width
- N_CLIENTS, 2, number of requesting masters (2..8)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- client_req_valid  in  N_CLIENTS  per-client read request valid
- client_req_ready  out  N_CLIENTS  per-client request accepted (one-hot pulse)
- client_addr  in  N_CLIENTS*AXI_AWIDTH  packed start addresses, client i at [i*AW +: AW]
- client_len  in  N_CLIENTS*32  packed burst lengths; beats = len+1
- client_size  in  N_CLIENTS*3  packed beat sizes
- client_burst  in  N_CLIENTS*2  packed burst types
- client_data  out  AXI_DWIDTH  read data, broadcast to all clients
- client_data_valid  out  N_CLIENTS  per-client data valid (granted client only)
- client_data_ready  in  N_CLIENTS  per-client data ready
- core_read_request_valid  out  1  request to core
- core_read_request_ready  in  1
- core_read_addr / core_read_len / core_read_size / core_read_burst  out  AW/32/3/2  registered request fields
- core_read_data  in  AXI_DWIDTH
- core_read_data_valid  in  1
- core_read_data_ready  out  1

Behaviour:
- Clocking and reset: one clock, clk; rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, grant=0, rr_ptr=0, beat_cnt=0.
  - All core_read_* request fields are 0.
  - All valid/ready outputs are 0.
- IDLE:
  - Pick the first asserted client_req_valid at or after rr_ptr, wrapping modulo N_CLIENTS.
  - On a pick:
    - register grant.
    - register the addr/len/size/burst of the granted client into the core_read_* fields.
    - set beat_cnt=len.
    - pulse client_req_ready[grant] for this cycle only.
    - move to REQ.
  - With no valid request, stay in IDLE.
- REQ:
  - core_read_request_valid=1, with fields held stable.
  - On core_read_request_ready, move to DATA.
  - Grant latency: the core request is valid the cycle after the client valid is sampled.
- DATA:
  - client_data_valid[grant]=core_read_data_valid; all other bits are 0.
  - core_read_data_ready=client_data_ready[grant].
  - On each valid&&ready beat:
    - if beat_cnt==0, this is the last beat: go to IDLE and set rr_ptr=(grant+1) mod N_CLIENTS.
    - else decrement beat_cnt.
- Outside DATA, core_read_data_ready=0 and client_data_valid=0. Beats arriving there are stalled, never dropped.
- client_data is always core_read_data, combinational.
- len=0 means one beat. len=0xFFFFFFFF is legal; beat_cnt is 32 bits and never wraps during a burst.
- Simultaneous requests are resolved by rr_ptr order only.
- A client deasserting valid after its req_ready pulse has no effect.
- A new request can be accepted from the IDLE cycle immediately after the last beat, which gives one bubble cycle per burst.
- rst_n asserted mid-burst: immediate return to reset values. Beats still in flight in the core belong to the core's own reset domain.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is neither instantiated nor updated; the search always starts at 0.
- Undefined: round-robin as specified above.

Decomposition:
- Package arb_pkg holds:
  - the state encoding localparams ST_IDLE=2'd0, ST_REQ=2'd1, ST_DATA=2'd2.
  - the beat counter width localparam BEAT_CNT_W=32.
  - the clog2 helper function.
- One sub-module, rr_picker: combinational pick of the first set bit of a request vector starting from a pointer.
  - Outputs: found, idx.
  - Under ARB_FIXED_PRIO_EN the pointer input is tied to 0.
- FSM, registers and muxing stay in read_burst_arbiter.

Test Plan:
- Single client, one beat:
  - Stimulus: client0 request, addr=0x1000, len=0; core ready immediately.
  - Required: core_read_request_valid one cycle after client valid; core_read_addr=0x1000, len=0; one data beat to client0; IDLE after it; rr_ptr=1.
- Contention:
  - Stimulus: clients 0 and 1 both valid every cycle, len=3 each.
  - Required: grants alternate 0,1,0,1; exactly 4 beats per grant; client_data_valid never asserted for the non-granted client.
- Backpressure:
  - Stimulus: client1 granted with len=7; client_data_ready[1] toggles 1,0,1,0.
  - Required: core_read_data_ready mirrors that pattern; exactly 8 beats counted; no beat lost or duplicated.
- Core request stall:
  - Stimulus: core_read_request_ready held low for 10 cycles.
  - Required: core_read_request_valid and all request fields stable for the full 10 cycles; no client_req_ready pulse beyond the first.
- Reset mid-burst:
  - Stimulus: assert rst_n low after beat 2 of a len=7 burst.
  - Required: asynchronously, all outputs go to 0 and state=IDLE; the next request is granted from client 0.
- ARB_FIXED_PRIO_EN build:
  - Stimulus: clients 0 and 1 continuously valid.
  - Required: client 0 is granted every time; client 1 is never granted.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared state encoding, counter width and sizing helper for read_burst_arbiter.
package arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam int unsigned BEAT_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    DATA = ST_DATA
  } arb_state_e;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 1) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/read_burst_arbiter_rr_picker.sv
// Combinational search for the first set request bit at or after ptr, wrapping modulo N.
module rr_picker
  import arb_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int unsigned j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[IDX_W'(j)]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/read_burst_arbiter.sv
// Burst-granular read-channel arbiter: one client owns the core read port until its last beat.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module read_burst_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned AXI_AWIDTH = 32,
  parameter int unsigned AXI_DWIDTH = 32,
  parameter int unsigned N_CLIENTS  = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_CLIENTS-1:0]            client_req_valid,
  output logic [N_CLIENTS-1:0]            client_req_ready,
  input  logic [N_CLIENTS*AXI_AWIDTH-1:0] client_addr,
  input  logic [N_CLIENTS*32-1:0]         client_len,
  input  logic [N_CLIENTS*3-1:0]          client_size,
  input  logic [N_CLIENTS*2-1:0]          client_burst,
  output logic [AXI_DWIDTH-1:0]           client_data,
  output logic [N_CLIENTS-1:0]            client_data_valid,
  input  logic [N_CLIENTS-1:0]            client_data_ready,
  output logic                            core_read_request_valid,
  input  logic                            core_read_request_ready,
  output logic [AXI_AWIDTH-1:0]           core_read_addr,
  output logic [31:0]                     core_read_len,
  output logic [2:0]                      core_read_size,
  output logic [1:0]                      core_read_burst,
  input  logic [AXI_DWIDTH-1:0]           core_read_data,
  input  logic                            core_read_data_valid,
  output logic                            core_read_data_ready
);

  localparam int unsigned IDX_W   = (clog2(N_CLIENTS) > 0) ? clog2(N_CLIENTS) : 1;
  localparam int unsigned LEN_W   = 32;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;

  arb_state_e              state, state_d;
  logic [IDX_W-1:0]        grant, grant_d;
  logic [BEAT_CNT_W-1:0]   beat_cnt, beat_cnt_d;
  logic [AXI_AWIDTH-1:0]   addr_d;
  logic [LEN_W-1:0]        len_d;
  logic [SIZE_W-1:0]       size_d;
  logic [BURST_W-1:0]      burst_d;
  logic                    req_valid_d;
  logic [N_CLIENTS-1:0]    req_ready_c;
  logic [N_CLIENTS-1:0]    data_valid_c;
  logic                    data_ready_c;
  logic                    pick_found;
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W-1:0]        pick_ptr;

`ifdef ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr, rr_ptr_d;
  assign pick_ptr = rr_ptr;
`endif

  rr_picker #(
    .N     (N_CLIENTS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (client_req_valid),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State register and registered request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= IDLE;
      grant                   <= '0;
      beat_cnt                <= '0;
      core_read_request_valid <= 1'b0;
      core_read_addr          <= '0;
      core_read_len           <= '0;
      core_read_size          <= '0;
      core_read_burst         <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr                  <= '0;
`endif
    end else begin
      state                   <= state_d;
      grant                   <= grant_d;
      beat_cnt                <= beat_cnt_d;
      core_read_request_valid <= req_valid_d;
      core_read_addr          <= addr_d;
      core_read_len           <= len_d;
      core_read_size          <= size_d;
      core_read_burst         <= burst_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr                  <= rr_ptr_d;
`endif
    end
  end

  // Next-state, grant capture and channel muxing.
  always_comb begin
    state_d      = state;
    grant_d      = grant;
    beat_cnt_d   = beat_cnt;
    addr_d       = core_read_addr;
    len_d        = core_read_len;
    size_d       = core_read_size;
    burst_d      = core_read_burst;
    req_ready_c  = '0;
    data_valid_c = '0;
    data_ready_c = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    rr_ptr_d     = rr_ptr;
`endif

    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_d               = pick_idx;
          addr_d                = client_addr[32'(pick_idx) * AXI_AWIDTH +: AXI_AWIDTH];
          len_d                 = client_len[32'(pick_idx) * LEN_W +: LEN_W];
          size_d                = client_size[32'(pick_idx) * SIZE_W +: SIZE_W];
          burst_d               = client_burst[32'(pick_idx) * BURST_W +: BURST_W];
          beat_cnt_d            = BEAT_CNT_W'(client_len[32'(pick_idx) * LEN_W +: LEN_W]);
          req_ready_c[pick_idx] = 1'b1;
          state_d               = REQ;
        end
      end
      REQ: begin
        if (core_read_request_ready) state_d = DATA;
      end
      DATA: begin
        data_valid_c[grant] = core_read_data_valid;
        data_ready_c        = client_data_ready[grant];
        if (core_read_data_valid && client_data_ready[grant]) begin
          if (beat_cnt == '0) begin
            state_d = IDLE;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr_d = (32'(grant) == N_CLIENTS - 1) ? '0 : grant + 1'b1;
`endif
          end else begin
            beat_cnt_d = beat_cnt - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    req_valid_d = (state_d == REQ);
  end

  // The accept pulse is the only output not already forced low by the reset state.
  assign client_req_ready     = req_ready_c & {N_CLIENTS{rst_n}};
  assign client_data_valid    = data_valid_c;
  assign core_read_data_ready = data_ready_c;
  assign client_data          = core_read_data;

endmodule

// File: tb/tb_read_burst_arbiter.sv
// Self-checking bench for read_burst_arbiter: directed scenarios plus randomized bursts against a burst-level model.
module tb_read_burst_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned N  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    client_req_valid, client_req_ready, client_data_valid, client_data_ready;
  logic [N*AW-1:0] client_addr;
  logic [N*32-1:0] client_len;
  logic [N*3-1:0]  client_size;
  logic [N*2-1:0]  client_burst;
  logic [DW-1:0]   client_data, core_read_data;
  logic            core_read_request_valid, core_read_request_ready;
  logic            core_read_data_valid, core_read_data_ready;
  logic [AW-1:0]   core_read_addr;
  logic [31:0]     core_read_len;
  logic [2:0]      core_read_size;
  logic [1:0]      core_read_burst;

  int tests = 0;
  int fails = 0;
  int m_ptr = 0;

  logic [AW-1:0] r_addr [N];
  logic [31:0]   r_len  [N];
  logic [2:0]    r_size [N];
  logic [1:0]    r_burst[N];

  always #5 clk = ~clk;

  read_burst_arbiter #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .N_CLIENTS(N)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .client_req_valid        (client_req_valid),
    .client_req_ready        (client_req_ready),
    .client_addr             (client_addr),
    .client_len              (client_len),
    .client_size             (client_size),
    .client_burst            (client_burst),
    .client_data             (client_data),
    .client_data_valid       (client_data_valid),
    .client_data_ready       (client_data_ready),
    .core_read_request_valid (core_read_request_valid),
    .core_read_request_ready (core_read_request_ready),
    .core_read_addr          (core_read_addr),
    .core_read_len           (core_read_len),
    .core_read_size          (core_read_size),
    .core_read_burst         (core_read_burst),
    .core_read_data          (core_read_data),
    .core_read_data_valid    (core_read_data_valid),
    .core_read_data_ready    (core_read_data_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < int'(N); k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic drive_fields();
    for (int i = 0; i < int'(N); i++) begin
      client_addr[i*AW +: AW] = r_addr[i];
      client_len[i*32 +: 32]  = r_len[i];
      client_size[i*3 +: 3]   = r_size[i];
      client_burst[i*2 +: 2]  = r_burst[i];
    end
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < int'(N); i++) begin
      client_addr[i*AW +: AW] = AW'($urandom);
      client_len[i*32 +: 32]  = 32'($urandom);
      client_size[i*3 +: 3]   = 3'($urandom);
      client_burst[i*2 +: 2]  = 2'($urandom);
    end
  endtask

  task automatic randomize_reqs(input int max_len);
    for (int i = 0; i < int'(N); i++) begin
      r_addr[i]  = AW'($urandom);
      r_len[i]   = 32'($urandom_range(0, max_len));
      r_size[i]  = 3'($urandom);
      r_burst[i] = 2'($urandom);
    end
  endtask

  // Drives every input that could leak through, so zero outputs are meaningful.
  task automatic reset_outputs_check();
    client_req_valid     = '1;
    core_read_data_valid = 1'b1;
    client_data_ready    = '1;
    #1;
    check("rst_req_ready",  64'(client_req_ready), 64'(0));
    check("rst_data_valid", 64'(client_data_valid), 64'(0));
    check("rst_data_ready", 64'(core_read_data_ready), 64'(0));
    check("rst_req_valid",  64'(core_read_request_valid), 64'(0));
    check("rst_addr",       64'(core_read_addr), 64'(0));
    check("rst_len",        64'(core_read_len), 64'(0));
    check("rst_size",       64'(core_read_size), 64'(0));
    check("rst_burst",      64'(core_read_burst), 64'(0));
  endtask

  task automatic idle_check();
    client_req_valid     = '0;
    core_read_data_valid = 1'b1;
    client_data_ready    = '1;
    #1;
    check("idle_req_ready",  64'(client_req_ready), 64'(0));
    check("idle_req_valid",  64'(core_read_request_valid), 64'(0));
    check("idle_data_valid", 64'(client_data_valid), 64'(0));
    check("idle_data_ready", 64'(core_read_data_ready), 64'(0));
    @(negedge clk);
  endtask

  // One burst from the IDLE cycle to the cycle after its last beat; entered and left at a negedge.
  // dv_mode 0: core data always valid, 1: random. dr_mode 0: always ready, 1: toggling, 2: random.
  task automatic run_txn(input logic [N-1:0] vmask, input int stall, input int dv_mode,
                         input int dr_mode, input bit drop, input int abort_at);
    int            g;
    logic [N-1:0]  onehot;
    logic [AW-1:0] ea;
    logic [31:0]   el;
    logic [2:0]    es;
    logic [1:0]    eb;
    logic [N-1:0]  dr;
    longint        beats;
    int            cyc;
    bit            tog;

    g = model_pick(vmask, m_ptr);
    onehot = '0;
    onehot[g] = 1'b1;
    ea = r_addr[g]; el = r_len[g]; es = r_size[g]; eb = r_burst[g];

    client_req_valid        = vmask;
    drive_fields();
    core_read_request_ready = 1'b1;
    core_read_data_valid    = 1'b1;
    client_data_ready       = '1;
    #1;
    check("grant_pulse",       64'(client_req_ready), 64'(onehot));
    check("idle_no_req_valid", 64'(core_read_request_valid), 64'(0));
    check("idle_no_data",      64'(client_data_valid), 64'(0));
    check("idle_stall_core",   64'(core_read_data_ready), 64'(0));
    @(negedge clk);

    client_req_valid = drop ? (vmask & ~onehot) : vmask;
    scramble_inputs();
    for (int s = 0; s <= stall; s++) begin
      core_read_request_ready = (s == stall);
      core_read_data_valid    = 1'(($urandom_range(0, 1)));
      #1;
      check("req_valid",     64'(core_read_request_valid), 64'(1));
      check("req_addr",      64'(core_read_addr), 64'(ea));
      check("req_len",       64'(core_read_len), 64'(el));
      check("req_size",      64'(core_read_size), 64'(es));
      check("req_burst",     64'(core_read_burst), 64'(eb));
      check("req_no_pulse",  64'(client_req_ready), 64'(0));
      check("req_no_data",   64'(client_data_valid), 64'(0));
      @(negedge clk);
    end
    core_read_request_ready = 1'b0;

    beats = 0;
    cyc   = 0;
    tog   = 1'b1;
    while (beats != longint'(el) + 1) begin
      if (abort_at >= 0 && beats == longint'(abort_at)) begin
        rst_n = 1'b0;
        reset_outputs_check();
        @(negedge clk);
        rst_n            = 1'b1;
        client_req_valid = '0;
        m_ptr            = 0;
        return;
      end
      if (cyc >= 2000) begin
        check("data_timeout", 64'(beats), 64'(el) + 64'(1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        return;
      end
      core_read_data_valid = (dv_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      core_read_data       = DW'($urandom);
      dr                   = N'($urandom);
      if (dr_mode == 0)      dr = '1;
      else if (dr_mode == 1) dr[g] = tog;
      client_data_ready = dr;
      tog = ~tog;
      #1;
      check("data_valid",   64'(client_data_valid), core_read_data_valid ? 64'(onehot) : 64'(0));
      check("data_ready",   64'(core_read_data_ready), 64'(dr[g]));
      check("data_bus",     64'(client_data), 64'(core_read_data));
      check("data_no_pulse",64'(client_req_ready), 64'(0));
      if (core_read_data_valid && dr[g]) beats++;
      cyc++;
      @(negedge clk);
    end
`ifndef ARB_FIXED_PRIO_EN
    m_ptr = (g + 1) % N;
`endif
  endtask

  initial begin
    logic [N-1:0] v;
    rst_n                   = 1'b0;
    core_read_request_ready = 1'b0;
    core_read_data          = '0;
    randomize_reqs(3);
    drive_fields();
    reset_outputs_check();
    @(negedge clk);
    rst_n            = 1'b1;
    client_req_valid = '0;

    // Single client, one beat.
    randomize_reqs(3);
    r_addr[0] = 32'h1000;
    r_len[0]  = 32'd0;
    run_txn(N'(1), 0, 0, 0, 1'b0, -1);
    idle_check();

    // Contention with both clients valid every cycle.
    for (int t = 0; t < 4; t++) begin
      randomize_reqs(3);
      for (int i = 0; i < int'(N); i++) r_len[i] = 32'd3;
      run_txn('1, 0, 0, 0, 1'b0, -1);
    end
    idle_check();

    // Backpressure on client 1.
    randomize_reqs(3);
    r_len[1] = 32'd7;
    run_txn(N'(2), 0, 0, 1, 1'b0, -1);

    // Core request stall with requester held valid.
    randomize_reqs(3);
    run_txn('1, 10, 1, 0, 1'b0, -1);

    // Reset mid-burst: client 0 moves the pointer, client 1 burst aborted after 3 beats.
    randomize_reqs(1);
    run_txn(N'(1), 0, 0, 0, 1'b0, -1);
    randomize_reqs(3);
    r_len[1] = 32'd7;
    run_txn(N'(2), 0, 0, 0, 1'b0, 3);
    randomize_reqs(2);
    run_txn('1, 0, 0, 0, 1'b0, -1);

    // Maximum length: counter must keep streaming, not wrap; aborted by reset.
    randomize_reqs(3);
    r_len[0] = 32'hFFFF_FFFF;
    run_txn(N'(1), 1, 0, 0, 1'b1, 6);

    // Randomized bursts.
    for (int t = 0; t < 30; t++) begin
      randomize_reqs(5);
      do v = N'($urandom); while (v == '0);
      run_txn(v, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 2),
              1'($urandom_range(0, 1)), -1);
    end
    idle_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
